// File: rtl/temp_poll_scheduler_if.sv
// Read handshake between the poll scheduler and the I2C temperature sensor controller.
// The scheduler drives the request; the sensor controller returns completion, error and sample.
interface temp_poll_scheduler_if;
  logic        rd_req;
  logic        rd_done;
  logic        rd_err;
  logic [11:0] rd_temp;

  modport master (
    output rd_req,
    input  rd_done,
    input  rd_err,
    input  rd_temp
  );

  modport slave (
    input  rd_req,
    output rd_done,
    output rd_err,
    output rd_temp
  );
endinterface

// File: rtl/temp_poll_scheduler.sv
// Periodic / on-demand temperature poll sequencer with timeout, bounded retry and backoff.
// Publishes the last good sample, an alarm with hysteresis, and sticky fault/overrun flags.
module temp_poll_scheduler #(
  parameter int unsigned POLL_PERIOD = 1_000_000,
  parameter int unsigned TIMEOUT     = 50_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned BACKOFF     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  temp_poll_scheduler_if.master        sens,
  input  logic                         i_enable,
  input  logic                         i_poll_now,
  input  logic                         i_clr_flags,
  input  logic [11:0]                  i_hi_thresh,
  input  logic [11:0]                  i_lo_thresh,
  output logic [11:0]                  o_temp_out,
  output logic                         o_temp_valid,
  output logic                         o_alarm,
  output logic                         o_fault,
  output logic                         o_overrun,
  output logic [15:0]                  o_sample_cnt
);

  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BO_LAST     = BW'(BACKOFF - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StBackoff} state_e;

  state_e         r_state;
  logic [PW-1:0]  r_period_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic [BW-1:0]  r_bo_cnt;
  logic [3:0]     r_retry_cnt;
  logic           r_rd_req;
  logic [11:0]    r_temp_out;
  logic           r_temp_valid;
  logic           r_alarm;
  logic           r_fault;
  logic           r_overrun;
  logic [15:0]    r_sample_cnt;

  logic           w_tick;
  logic           w_poll_req;
  logic           w_success;
  logic           w_fail;
  logic [3:0]     w_retry_next;
  logic           w_at_hi;
  logic           w_at_lo;

  assign w_tick       = i_enable && (r_period_cnt == PERIOD_LAST);
  assign w_poll_req   = w_tick || (i_poll_now && i_enable);
  // A completion in the final timeout cycle still counts as success.
  assign w_success    = sens.rd_done && !sens.rd_err;
  assign w_fail       = (sens.rd_done && sens.rd_err) || (!sens.rd_done && (r_to_cnt == TO_LAST));
  assign w_retry_next = r_retry_cnt + 4'd1;
  assign w_at_hi      = $signed(sens.rd_temp) >= $signed(i_hi_thresh);
  assign w_at_lo      = $signed(sens.rd_temp) <= $signed(i_lo_thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (!i_enable || (r_period_cnt == PERIOD_LAST)) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_to_cnt     <= '0;
      r_bo_cnt     <= '0;
      r_retry_cnt  <= '0;
      r_rd_req     <= 1'b0;
      r_temp_out   <= 12'h190;
      r_temp_valid <= 1'b0;
      r_alarm      <= 1'b0;
      r_fault      <= 1'b0;
      r_overrun    <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_rd_req     <= 1'b0;
      r_temp_valid <= 1'b0;
      // Clear first so that a same-cycle set below takes priority.
      if (i_clr_flags) begin
        r_fault   <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_poll_req && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_poll_req) begin
            r_state     <= StIssue;
            r_rd_req    <= 1'b1;
            r_retry_cnt <= '0;
          end
        end
        StIssue: begin
          r_state  <= StWaitDone;
          r_to_cnt <= '0;
        end
        StWaitDone: begin
          if (w_success) begin
            r_state      <= StIdle;
            r_temp_out   <= sens.rd_temp;
            r_temp_valid <= 1'b1;
            r_sample_cnt <= r_sample_cnt + 16'd1;
            if (w_at_hi) begin
              r_alarm <= 1'b1;
            end else if (w_at_lo) begin
              r_alarm <= 1'b0;
            end
          end else if (w_fail) begin
            r_retry_cnt <= w_retry_next;
            if (w_retry_next == RETRY_MAX) begin
              r_fault <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_state  <= StBackoff;
              r_bo_cnt <= '0;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        StBackoff: begin
          if (r_bo_cnt == BO_LAST) begin
            r_state  <= StIssue;
            r_rd_req <= 1'b1;
          end else begin
            r_bo_cnt <= r_bo_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sens.rd_req  = r_rd_req;
  assign o_temp_out   = r_temp_out;
  assign o_temp_valid = r_temp_valid;
  assign o_alarm      = r_alarm;
  assign o_fault      = r_fault;
  assign o_overrun    = r_overrun;
  assign o_sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_temp_poll_scheduler.sv
// Directed bench for temp_poll_scheduler: periodic polls, alarm hysteresis, timeout/retry,
// error recovery, overrun/disable and reset during backoff, with hand-computed expectations.
module tb_temp_poll_scheduler;

  localparam int unsigned PP = 100;
  localparam int unsigned TO = 20;
  localparam int unsigned MR = 3;
  localparam int unsigned BO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        poll_now;
  logic        clr_flags;
  logic [11:0] hi_thresh;
  logic [11:0] lo_thresh;
  logic [11:0] temp_out;
  logic        temp_valid;
  logic        alarm;
  logic        fault;
  logic        overrun;
  logic [15:0] sample_cnt;

  temp_poll_scheduler_if sens ();

  temp_poll_scheduler #(
    .POLL_PERIOD (PP),
    .TIMEOUT     (TO),
    .MAX_RETRY   (MR),
    .BACKOFF     (BO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sens         (sens),
    .i_enable     (enable),
    .i_poll_now   (poll_now),
    .i_clr_flags  (clr_flags),
    .i_hi_thresh  (hi_thresh),
    .i_lo_thresh  (lo_thresh),
    .o_temp_out   (temp_out),
    .o_temp_valid (temp_valid),
    .o_alarm      (alarm),
    .o_fault      (fault),
    .o_overrun    (overrun),
    .o_sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string tag, output int at);
    bit seen;
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      if (sens.rd_req) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic respond(input int dly, input logic err, input logic [11:0] t);
    tick(dly);
    sens.rd_done = 1'b1;
    sens.rd_err  = err;
    sens.rd_temp = t;
    tick(1);
    sens.rd_done = 1'b0;
    sens.rd_err  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    poll_now     = 1'b0;
    clr_flags    = 1'b0;
    sens.rd_done = 1'b0;
    sens.rd_err  = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          prev;
    int          at;
    int          at2;
    int          nreq;
    logic [11:0] s2_t [5];
    logic        s2_a [5];

    s2_t[0] = 12'h210; s2_a[0] = 1'b1;
    s2_t[1] = 12'h190; s2_a[1] = 1'b1;
    s2_t[2] = 12'h170; s2_a[2] = 1'b0;
    s2_t[3] = 12'h200; s2_a[3] = 1'b1;  // equal to hi sets
    s2_t[4] = 12'hF00; s2_a[4] = 1'b0;  // negative, must compare signed

    hi_thresh    = 12'h200;
    lo_thresh    = 12'h180;
    sens.rd_temp = 12'h000;
    apply_reset();

    check("rst_temp_out", 32'(temp_out), 32'h190);
    check("rst_temp_valid", 32'(temp_valid), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("rst_rd_req", 32'(sens.rd_req), 32'd0);

    // Periodic polling
    enable = 1'b1;
    prev   = cyc;
    for (int p = 0; p < 3; p++) begin
      wait_req("s1_req", at);
      check("s1_gap", 32'(at - prev), 32'd100);
      prev = at;
      tick(1);
      check("s1_req_pulse", 32'(sens.rd_req), 32'd0);
      respond(4, 1'b0, 12'h1A0);
      check("s1_valid", 32'(temp_valid), 32'd1);
      check("s1_temp", 32'(temp_out), 32'h1A0);
      tick(1);
      check("s1_valid_drop", 32'(temp_valid), 32'd0);
    end
    check("s1_cnt", 32'(sample_cnt), 32'd3);
    check("s1_alarm", 32'(alarm), 32'd0);

    // Alarm hysteresis
    for (int k = 0; k < 5; k++) begin
      wait_req("s2_req", at);
      respond(5, 1'b0, s2_t[k]);
      check("s2_alarm", 32'(alarm), 32'(s2_a[k]));
    end
    check("s2_cnt", 32'(sample_cnt), 32'd8);

    // Timeout and retry, no response at all
    apply_reset();
    enable = 1'b1;
    wait_req("s3_req1", at);
    wait_req("s3_req2", at2);
    check("s3_gap12", 32'(at2 - at), 32'd25);
    wait_req("s3_req3", at);
    check("s3_gap23", 32'(at - at2), 32'd25);
    tick(20);
    check("s3_fault_early", 32'(fault), 32'd0);
    tick(1);
    check("s3_fault", 32'(fault), 32'd1);
    check("s3_temp_kept", 32'(temp_out), 32'h190);
    check("s3_cnt", 32'(sample_cnt), 32'd0);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    check("s3_fault_clr", 32'(fault), 32'd0);

    // Error then success
    wait_req("s4_req1", at);
    respond(5, 1'b1, 12'h000);
    wait_req("s4_req2", at2);
    check("s4_retry_gap", 32'(at2 - at), 32'd10);
    respond(5, 1'b0, 12'h0F0);
    check("s4_valid", 32'(temp_valid), 32'd1);
    check("s4_temp", 32'(temp_out), 32'h0F0);
    check("s4_fault", 32'(fault), 32'd0);
    check("s4_cnt", 32'(sample_cnt), 32'd1);

    // Overrun, clear-vs-set priority, disable mid-transaction
    wait_req("s5_req", at);
    tick(1);
    check("s5_ovr_before", 32'(overrun), 32'd0);
    poll_now = 1'b1;
    tick(1);
    poll_now = 1'b0;
    check("s5_ovr_set", 32'(overrun), 32'd1);
    clr_flags = 1'b1;
    poll_now  = 1'b1;
    tick(1);
    poll_now  = 1'b0;
    check("s5_ovr_set_wins", 32'(overrun), 32'd1);
    tick(1);
    clr_flags = 1'b0;
    check("s5_ovr_clr", 32'(overrun), 32'd0);
    enable = 1'b0;
    respond(2, 1'b0, 12'h1A0);
    check("s5_valid", 32'(temp_valid), 32'd1);
    check("s5_temp", 32'(temp_out), 32'h1A0);
    check("s5_cnt", 32'(sample_cnt), 32'd2);
    nreq = 0;
    repeat (250) begin
      tick(1);
      if (sens.rd_req) nreq++;
    end
    check("s5_no_req", 32'(nreq), 32'd0);

    // Reset while in backoff
    enable = 1'b1;
    wait_req("s6_req", at);
    tick(22);
    rst_n = 1'b0;
    #1;
    check("s6_temp_out", 32'(temp_out), 32'h190);
    check("s6_rd_req", 32'(sens.rd_req), 32'd0);
    check("s6_valid", 32'(temp_valid), 32'd0);
    check("s6_alarm", 32'(alarm), 32'd0);
    check("s6_fault", 32'(fault), 32'd0);
    check("s6_overrun", 32'(overrun), 32'd0);
    check("s6_cnt", 32'(sample_cnt), 32'd0);
    tick(2);
    check("s6_rd_req_hold", 32'(sens.rd_req), 32'd0);
    rst_n = 1'b1;
    prev  = cyc;
    wait_req("s6_req_after", at);
    check("s6_gap", 32'(at - prev), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
